// File: rtl/uart_bus_bridge_pkg.sv
// Shared constants and state types for the UART-to-bus bridge.
// Optional feature: define UART_BUS_BRIDGE_CHECKSUM_EN to add XOR checksum bytes
// to every request and every response.
package uart_bus_bridge_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned RSP_MAX = 5;

    localparam logic [7:0] CMD_WR     = 8'h57;
    localparam logic [7:0] CMD_RD     = 8'h52;
    localparam logic [7:0] RSP_ACK    = 8'h4B;
    localparam logic [7:0] RSP_BADCMD = 8'h3F;
    localparam logic [7:0] RSP_BADSUM = 8'h21;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StBus,
        StResp,
        StTxwait
`ifdef UART_BUS_BRIDGE_CHECKSUM_EN
        , StCsum
`endif
    } state_e;

    typedef enum logic [1:0] {
        SerIdle,
        SerSend,
        SerWaitLow,
        SerWaitHigh
    } ser_state_e;

`ifdef UART_BUS_BRIDGE_CHECKSUM_EN
    // Single-byte responses carry a checksum equal to the byte itself.
    localparam logic [2:0] RSP_LEN_SHORT = 3'd2;
    localparam logic [2:0] RSP_LEN_READ  = 3'd5;
    localparam state_e     StReqEnd      = StCsum;
`else
    localparam logic [2:0] RSP_LEN_SHORT = 3'd1;
    localparam logic [2:0] RSP_LEN_READ  = 3'd4;
    localparam state_e     StReqEnd      = StBus;
`endif

    function automatic logic [7:0] xor_bytes(input logic [31:0] d);
        return d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
    endfunction

endpackage

// File: rtl/uart_bus_bridge_if.sv
// UART byte stream and peripheral bus signals seen by the bridge.
interface uart_bus_bridge_if;
    import uart_bus_bridge_pkg::*;

    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] Address;
    logic [31:0]       Write_data;
    logic [31:0]       Read_data;
    logic              busy;
    logic              err;

    modport master (
        input  rx_valid, rx_data, tx_ready, Read_data,
        output tx_start, tx_data, MemRead, MemWrite, Address, Write_data, busy, err
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, Read_data,
        input  tx_start, tx_data, MemRead, MemWrite, Address, Write_data, busy, err
    );
endinterface

// File: rtl/bridge_tx_serializer.sv
// Sends up to RSP_MAX response bytes, MSB first, over the tx_start/tx_ready handshake.
module bridge_tx_serializer
    import uart_bus_bridge_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_load,
    input  logic [RSP_MAX*8-1:0] i_bytes,
    input  logic [2:0]           i_len,
    input  logic                 i_tx_ready,
    output logic                 o_tx_start,
    output logic [7:0]           o_tx_data,
    output logic                 o_next,
    output logic                 o_done
);
    ser_state_e           r_phase, w_phase_d;
    logic [RSP_MAX*8-1:0] r_buf, w_buf_d;
    logic [2:0]           r_left, w_left_d;
    logic                 w_start;

    // Phase, byte buffer and remaining-byte count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= SerIdle;
            r_buf   <= '0;
            r_left  <= '0;
        end else begin
            r_phase <= w_phase_d;
            r_buf   <= w_buf_d;
            r_left  <= w_left_d;
        end
    end

    // One byte per tx_ready high->low->high cycle of the sender.
    always_comb begin
        w_phase_d = r_phase;
        w_buf_d   = r_buf;
        w_left_d  = r_left;
        w_start   = 1'b0;
        o_next    = 1'b0;
        o_done    = 1'b0;
        unique case (r_phase)
            SerIdle: begin
                if (i_load) begin
                    w_buf_d   = i_bytes;
                    w_left_d  = i_len;
                    w_phase_d = SerSend;
                end
            end
            SerSend: begin
                if (i_tx_ready) begin
                    w_start   = 1'b1;
                    w_phase_d = SerWaitLow;
                end
            end
            SerWaitLow: begin
                if (!i_tx_ready) w_phase_d = SerWaitHigh;
            end
            SerWaitHigh: begin
                if (i_tx_ready) begin
                    if (r_left > 3'd1) begin
                        w_left_d  = r_left - 3'd1;
                        w_buf_d   = {r_buf[RSP_MAX*8-9:0], 8'h00};
                        w_phase_d = SerSend;
                        o_next    = 1'b1;
                    end else begin
                        w_phase_d = SerIdle;
                        o_done    = 1'b1;
                    end
                end
            end
            default: w_phase_d = SerIdle;
        endcase
    end

    // Reset suppresses a start pulse in the cycle it is asserted.
    assign o_tx_start = w_start & ~reset;
    assign o_tx_data  = r_buf[RSP_MAX*8-1 -: 8];

endmodule

// File: rtl/uart_bus_bridge.sv
// UART-driven bus initiator: parses write/read command frames, issues one-cycle
// bus strobes and returns an ack or read data through the tx serializer.
// Optional feature: define UART_BUS_BRIDGE_CHECKSUM_EN for XOR-checked frames.
module uart_bus_bridge
    import uart_bus_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd1_000_000
) (
    input logic               clk,
    input logic               reset,
    uart_bus_bridge_if.master bus_if
);
    state_e               r_state, w_state_d;
    logic                 r_is_wr, w_is_wr_d;
    logic [1:0]           r_nbyte, w_nbyte_d;
    logic [ADDR_W-1:0]    r_addr, w_addr_d;
    logic [31:0]          r_wdata, w_wdata_d;
    logic [31:0]          r_tmo, w_tmo_d;
    logic                 w_tmo_hit;
    logic                 w_load;
    logic [RSP_MAX*8-1:0] w_rsp_bytes;
    logic [2:0]           w_rsp_len;
    logic                 w_rd, w_wr, w_err;
    logic                 w_tx_start, w_ser_next, w_ser_done;
`ifdef UART_BUS_BRIDGE_CHECKSUM_EN
    logic [7:0]           r_sum, w_sum_d;
`endif

    // Frame parser state and captured fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_is_wr <= 1'b0;
            r_nbyte <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_tmo   <= '0;
`ifdef UART_BUS_BRIDGE_CHECKSUM_EN
            r_sum   <= '0;
`endif
        end else begin
            r_state <= w_state_d;
            r_is_wr <= w_is_wr_d;
            r_nbyte <= w_nbyte_d;
            r_addr  <= w_addr_d;
            r_wdata <= w_wdata_d;
            r_tmo   <= w_tmo_d;
`ifdef UART_BUS_BRIDGE_CHECKSUM_EN
            r_sum   <= w_sum_d;
`endif
        end
    end

    assign w_tmo_hit = (r_tmo == TIMEOUT_CYCLES - 32'd1);

    // Next-state, bus strobes and response loading; timeout beats a same-cycle byte.
    always_comb begin
        w_state_d   = r_state;
        w_is_wr_d   = r_is_wr;
        w_nbyte_d   = r_nbyte;
        w_addr_d    = r_addr;
        w_wdata_d   = r_wdata;
        w_tmo_d     = '0;
        w_load      = 1'b0;
        w_rsp_bytes = '0;
        w_rsp_len   = '0;
        w_rd        = 1'b0;
        w_wr        = 1'b0;
        w_err       = 1'b0;
`ifdef UART_BUS_BRIDGE_CHECKSUM_EN
        w_sum_d     = r_sum;
`endif
        unique case (r_state)
            StIdle: begin
                if (bus_if.rx_valid) begin
                    if (bus_if.rx_data == CMD_WR || bus_if.rx_data == CMD_RD) begin
                        w_is_wr_d = (bus_if.rx_data == CMD_WR);
                        w_nbyte_d = '0;
                        w_state_d = StAddr;
`ifdef UART_BUS_BRIDGE_CHECKSUM_EN
                        w_sum_d   = bus_if.rx_data;
`endif
                    end else begin
                        w_load      = 1'b1;
                        w_rsp_bytes = {RSP_BADCMD, RSP_BADCMD, 24'h0};
                        w_rsp_len   = RSP_LEN_SHORT;
                        w_err       = 1'b1;
                        w_state_d   = StResp;
                    end
                end
            end
            StAddr: begin
                if (w_tmo_hit) begin
                    w_err     = 1'b1;
                    w_state_d = StIdle;
                end else if (bus_if.rx_valid) begin
                    w_addr_d  = {r_addr[ADDR_W-9:0], bus_if.rx_data};
                    w_nbyte_d = r_nbyte + 2'd1;
`ifdef UART_BUS_BRIDGE_CHECKSUM_EN
                    w_sum_d   = r_sum ^ bus_if.rx_data;
`endif
                    if (r_nbyte == 2'd3) w_state_d = r_is_wr ? StData : StReqEnd;
                end else begin
                    w_tmo_d = r_tmo + 32'd1;
                end
            end
            StData: begin
                if (w_tmo_hit) begin
                    w_err     = 1'b1;
                    w_state_d = StIdle;
                end else if (bus_if.rx_valid) begin
                    w_wdata_d = {r_wdata[23:0], bus_if.rx_data};
                    w_nbyte_d = r_nbyte + 2'd1;
`ifdef UART_BUS_BRIDGE_CHECKSUM_EN
                    w_sum_d   = r_sum ^ bus_if.rx_data;
`endif
                    if (r_nbyte == 2'd3) w_state_d = StReqEnd;
                end else begin
                    w_tmo_d = r_tmo + 32'd1;
                end
            end
`ifdef UART_BUS_BRIDGE_CHECKSUM_EN
            StCsum: begin
                if (w_tmo_hit) begin
                    w_err     = 1'b1;
                    w_state_d = StIdle;
                end else if (bus_if.rx_valid) begin
                    if (bus_if.rx_data == r_sum) begin
                        w_state_d = StBus;
                    end else begin
                        w_load      = 1'b1;
                        w_rsp_bytes = {RSP_BADSUM, RSP_BADSUM, 24'h0};
                        w_rsp_len   = RSP_LEN_SHORT;
                        w_err       = 1'b1;
                        w_state_d   = StResp;
                    end
                end else begin
                    w_tmo_d = r_tmo + 32'd1;
                end
            end
`endif
            StBus: begin
                w_wr      = r_is_wr;
                w_rd      = ~r_is_wr;
                w_load    = 1'b1;
                w_state_d = StResp;
                if (r_is_wr) begin
                    w_rsp_bytes = {RSP_ACK, RSP_ACK, 24'h0};
                    w_rsp_len   = RSP_LEN_SHORT;
                end else begin
                    w_rsp_bytes = {bus_if.Read_data, xor_bytes(bus_if.Read_data)};
                    w_rsp_len   = RSP_LEN_READ;
                end
            end
            StResp: begin
                if (w_tx_start) w_state_d = StTxwait;
            end
            StTxwait: begin
                if (w_ser_done)      w_state_d = StIdle;
                else if (w_ser_next) w_state_d = StResp;
            end
            default: w_state_d = StIdle;
        endcase
    end

    bridge_tx_serializer u_tx_ser (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_bytes    (w_rsp_bytes),
        .i_len      (w_rsp_len),
        .i_tx_ready (bus_if.tx_ready),
        .o_tx_start (w_tx_start),
        .o_tx_data  (bus_if.tx_data),
        .o_next     (w_ser_next),
        .o_done     (w_ser_done)
    );

    assign bus_if.tx_start   = w_tx_start;
    assign bus_if.MemRead    = w_rd & ~reset;
    assign bus_if.MemWrite   = w_wr & ~reset;
    assign bus_if.err        = w_err & ~reset;
    assign bus_if.Address    = r_addr;
    assign bus_if.Write_data = r_wdata;
    assign bus_if.busy       = (r_state != StIdle);

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Randomised bench for uart_bus_bridge against a frame-level reference model.
module tb_uart_bus_bridge;

    localparam int TMO = 100;
`ifdef UART_BUS_BRIDGE_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_bus_bridge_if u_if ();

    uart_bus_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (u_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state, written only by the monitor process.
    int          cyc = 0;
    int          n_rd = 0, n_wr = 0, n_err = 0, n_both = 0, n_tx_bad = 0;
    int          strobe_cyc = 0, err_cyc = 0, last_rx_cyc = 0;
    logic [31:0] obs_addr = '0, obs_wdata = '0;
    logic [7:0]  tx_q[$];
    int          tx_cyc_q[$];
    bit          injecting = 1'b0;

    logic [7:0]  frm[$];
    logic [7:0]  exp_rsp[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (u_if.rx_valid && !injecting) last_rx_cyc = cyc;
        if (u_if.MemRead) begin
            n_rd++;
            strobe_cyc = cyc;
            obs_addr   = u_if.Address;
        end
        if (u_if.MemWrite) begin
            n_wr++;
            strobe_cyc = cyc;
            obs_addr   = u_if.Address;
            obs_wdata  = u_if.Write_data;
        end
        if (u_if.MemRead && u_if.MemWrite) n_both++;
        if (u_if.err) begin
            n_err++;
            err_cyc = cyc;
        end
        if (u_if.tx_start) begin
            tx_q.push_back(u_if.tx_data);
            tx_cyc_q.push_back(cyc);
            if (!u_if.tx_ready) n_tx_bad++;
        end
    end

    // UART sender model: goes busy for 1..4 cycles after each start.
    initial begin
        u_if.tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (u_if.tx_start) begin
                @(posedge clk);
                #1 u_if.tx_ready = 1'b0;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1 u_if.tx_ready = 1'b1;
            end
        end
    end

    task automatic build(input int kind, input logic [31:0] a, input logic [31:0] d);
        logic [7:0] op;
        logic [7:0] x;
        int keep;
        frm.delete();
        if (kind == 2) begin
            do op = 8'($urandom); while (op == 8'h57 || op == 8'h52);
            frm.push_back(op);
            return;
        end
        op = (kind == 0 || (kind == 3 && $urandom_range(0, 1) == 0)) ? 8'h57 : 8'h52;
        frm.push_back(op);
        for (int i = 3; i >= 0; i--) frm.push_back(a[8*i +: 8]);
        if (op == 8'h57) for (int i = 3; i >= 0; i--) frm.push_back(d[8*i +: 8]);
        if (CS != 0) begin
            x = 8'h00;
            foreach (frm[i]) x ^= frm[i];
            if (kind == 4) x ^= 8'(8'h01 << $urandom_range(0, 7));
            frm.push_back(x);
        end
        if (kind == 3) begin
            keep = $urandom_range(1, frm.size() - 1);
            while (frm.size() > keep) void'(frm.pop_back());
        end
    endtask

    // Frame-level expectations straight from the command/response rules.
    task automatic model(input logic [31:0] rdata, output int op, output logic [31:0] addr,
                         output logic [31:0] wdata, output int nerr, output bit tmo);
        int need;
        logic [7:0] x;
        exp_rsp.delete();
        op = 0; addr = '0; wdata = '0; nerr = 0; tmo = 1'b0;
        if (frm[0] != 8'h57 && frm[0] != 8'h52) begin
            nerr = 1;
            exp_rsp.push_back(8'h3F);
        end else begin
            need = (frm[0] == 8'h57 ? 9 : 5) + CS;
            if (frm.size() < need) begin
                nerr = 1;
                tmo  = 1'b1;
            end else begin
                addr = {frm[1], frm[2], frm[3], frm[4]};
                if (frm[0] == 8'h57) wdata = {frm[5], frm[6], frm[7], frm[8]};
                x = 8'h00;
                for (int i = 0; i < need - 1; i++) x ^= frm[i];
                if (CS != 0 && x != frm[need-1]) begin
                    nerr = 1;
                    exp_rsp.push_back(8'h21);
                end else if (frm[0] == 8'h57) begin
                    op = 2;
                    exp_rsp.push_back(8'h4B);
                end else begin
                    op = 1;
                    for (int i = 3; i >= 0; i--) exp_rsp.push_back(rdata[8*i +: 8]);
                end
            end
        end
        if (CS != 0 && exp_rsp.size() > 0) begin
            x = 8'h00;
            foreach (exp_rsp[i]) x ^= exp_rsp[i];
            exp_rsp.push_back(x);
        end
    endtask

    task automatic send_frame();
        foreach (frm[i]) begin
            if (i > 0) repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk);
            #1 u_if.rx_valid = 1'b1;
            u_if.rx_data = frm[i];
            @(posedge clk);
            #1 u_if.rx_valid = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [31:0] rdata, input bit inject);
        int b_rd, b_wr, b_err, b_tx, op, nerr, waited;
        logic [31:0] e_addr, e_wdata;
        bit tmo;
        b_rd = n_rd; b_wr = n_wr; b_err = n_err; b_tx = tx_q.size();
        model(rdata, op, e_addr, e_wdata, nerr, tmo);
        u_if.Read_data = rdata;
        send_frame();
        injecting = inject;
        waited = 0;
        do begin
            @(posedge clk);
            #2;
            if (inject && u_if.busy && !u_if.tx_ready) begin
                u_if.rx_valid = 1'b1;
                u_if.rx_data  = 8'($urandom);
            end else begin
                u_if.rx_valid = 1'b0;
            end
            waited++;
        end while (u_if.busy && waited < 400);
        u_if.rx_valid = 1'b0;
        injecting = 1'b0;
        check_eq("frame_done", u_if.busy, 0);
        check_eq("rd_count", n_rd - b_rd, (op == 1));
        check_eq("wr_count", n_wr - b_wr, (op == 2));
        check_eq("err_count", n_err - b_err, nerr);
        check_eq("tx_len", tx_q.size() - b_tx, exp_rsp.size());
        for (int i = 0; i < exp_rsp.size() && b_tx + i < tx_q.size(); i++)
            check_eq($sformatf("tx_byte%0d", i), tx_q[b_tx+i], exp_rsp[i]);
        if (op != 0) begin
            check_eq("address", obs_addr, e_addr);
            check_eq("rx_to_strobe", strobe_cyc - last_rx_cyc, 1);
            if (tx_q.size() > b_tx) check_eq("strobe_to_tx", tx_cyc_q[b_tx] - strobe_cyc, 1);
        end
        if (op == 2) check_eq("write_data", obs_wdata, e_wdata);
        if (tmo) check_eq("timeout_cycles", err_cyc - last_rx_cyc, TMO);
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq(tag, {u_if.tx_start, u_if.tx_data, u_if.MemRead, u_if.MemWrite, u_if.Address,
                       u_if.Write_data, u_if.busy, u_if.err}, '0);
    endtask

    initial begin
        int b_rd, b_tx, waited, kind;
        logic [31:0] rdata;
        reset          = 1'b1;
        u_if.rx_valid  = 1'b0;
        u_if.rx_data   = '0;
        u_if.Read_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outs("reset_state");

        build(0, 32'h4000000C, 32'h000000A5);
        run_frame(32'h0, 1'b0);
        build(1, 32'h40000010, 32'h0);
        run_frame(32'h0000003C, 1'b1);
        build(2, 32'h0, 32'h0);
        frm[0] = 8'h13;
        run_frame(32'h0, 1'b0);
        frm.delete();
        frm.push_back(8'h52); frm.push_back(8'h40); frm.push_back(8'h00);
        run_frame(32'h0, 1'b0);
        build(1, 32'h40000008, 32'h0);
        run_frame(32'h12345678, 1'b0);
        if (CS != 0) begin
            build(4, 32'h40000008, 32'h0);
            run_frame(32'hCAFEF00D, 1'b0);
        end

        // Reset while the second byte of a read response is in flight.
        build(1, 32'h40000020, 32'h0);
        rdata = 32'hA1B2C3D4;
        u_if.Read_data = rdata;
        b_rd = n_rd;
        b_tx = tx_q.size();
        send_frame();
        waited = 0;
        while (tx_q.size() < b_tx + 2 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check_eq("rst_mid_bytes_seen", tx_q.size() - b_tx, 2);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outs("reset_mid_rsp");
        repeat (60) @(posedge clk);
        check_eq("rst_tx_total", tx_q.size() - b_tx, 2);
        check_eq("rst_rd_count", n_rd - b_rd, 1);
        if (tx_q.size() >= b_tx + 2) begin
            check_eq("rst_byte0", tx_q[b_tx], rdata[31:24]);
            check_eq("rst_byte1", tx_q[b_tx+1], rdata[23:16]);
        end

        for (int n = 0; n < 24; n++) begin
            kind = $urandom_range(0, (CS != 0) ? 4 : 3);
            build(kind, $urandom, $urandom);
            run_frame($urandom, $urandom_range(0, 1) == 1);
        end

        check_eq("strobe_overlap", n_both, 0);
        check_eq("tx_start_not_ready", n_tx_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
